// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//
// Memory-access stage of the RV64 NPC core. Takes the decoded load/store
// controls plus the ALU address and store data, runs one valid/ready
// transaction on an 8-byte data bus, and returns the aligned and
// sign/zero-extended load result. mem_finish tells control the stage may
// retire this cycle.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   When defined, misaligned accesses skip the bus and report err for one
//   cycle in DONE. When undefined, err is tied to 0 and misaligned accesses
//   simply truncate at the word boundary.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid           instruction present in MEM stage
//   data_ram_en/wen     load / store request (store wins if both set)
//   l_choose            one-hot load type [0]ld [1]lw [2]lwu [3]lh [4]lhu
//                       [5]lb [6]lbu (zero means ld, lowest set bit wins)
//   wmask, wdata, addr  unshifted store mask/data and byte address
//   mem_finish, rdata   retire strobe and extended load result
//   busy                transaction in flight
//   mem_req_*           bus request channel (valid/ready)
//   mem_resp_*          bus response channel (valid/ready)
//   err                 misaligned access flag
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              data_ram_en,
    input  logic              data_ram_wen,
    input  logic [6:0]        l_choose,
    input  logic [7:0]        wmask,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              mem_finish,
    output logic [XLEN-1:0]   rdata,
    output logic              busy,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [7:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    output logic              mem_resp_ready,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [7:0]        r_wmask;
    logic [6:0]        r_lchoose;
    logic              r_wen;
    logic [XLEN-1:0]   r_rdata;

    logic              w_start;
    logic              w_misalign;
    logic [5:0]        w_shamt;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_loadVal;

`ifdef LSU_MISALIGN_CHECK_EN
    logic              r_err;
`endif

    assign w_start   = req_valid & (data_ram_en | data_ram_wen);
    assign w_shamt   = {r_addr[2:0], 3'b000};
    assign w_shifted = mem_resp_rdata >> w_shamt;

    // Alignment check on the incoming request. Store size comes from the
    // highest populated group of the mask; load size from the same
    // lowest-bit-wins decode used for extraction.
`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        if (data_ram_wen) begin
            if (wmask[7:4] != 4'h0)      w_misalign = (addr[2:0] != 3'b000);
            else if (wmask[3:2] != 2'b0) w_misalign = (addr[1:0] != 2'b00);
            else if (wmask[1])           w_misalign = addr[0];
            else                         w_misalign = 1'b0;
        end else begin
            casez (l_choose)
                7'b0000000,
                7'b??????1: w_misalign = (addr[2:0] != 3'b000);
                7'b?????10,
                7'b????100: w_misalign = (addr[1:0] != 2'b00);
                7'b???1000,
                7'b??10000: w_misalign = addr[0];
                default:    w_misalign = 1'b0;
            endcase
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Load extraction: the response word is shifted down by the byte offset
    // and then extended according to the latched load type. An all-zero
    // type falls into the ld arm.
    always_comb begin
        w_loadVal = w_shifted;
        casez (r_lchoose)
            7'b0000000,
            7'b??????1: w_loadVal = w_shifted;
            7'b?????10: w_loadVal = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            7'b????100: w_loadVal = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            7'b???1000: w_loadVal = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            7'b??10000: w_loadVal = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            7'b?100000: w_loadVal = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            default:    w_loadVal = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs. A non-memory instruction finishes
    // combinationally in IDLE so it adds no latency.
    always_comb begin
        w_next         = r_state;
        mem_finish     = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = w_misalign ? S_DONE : S_REQ;
                end else if (req_valid) begin
                    mem_finish = 1'b1;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                mem_resp_ready = 1'b1;
                if (mem_resp_valid) w_next = S_DONE;
            end
            S_DONE: begin
                mem_finish = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request fields are latched on acceptance in IDLE and held until the
    // next request, so they stay stable for the whole REQ phase. The result
    // register is written when the response is taken; stores read back 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_lchoose <= '0;
            r_wen     <= 1'b0;
            r_rdata   <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr    <= addr;
                        r_wdata   <= wdata;
                        r_wmask   <= wmask;
                        r_lchoose <= l_choose;
                        r_wen     <= data_ram_wen;
`ifdef LSU_MISALIGN_CHECK_EN
                        if (w_misalign) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) r_rdata <= r_wen ? '0 : w_loadVal;
                end
                S_DONE: begin
`ifdef LSU_MISALIGN_CHECK_EN
                    r_err <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign rdata         = r_rdata;
    assign mem_req_wen   = r_wen;
    assign mem_req_addr  = {r_addr[ADDR_W-1:3], 3'b000};
    assign mem_req_wdata = r_wdata << w_shamt;
    assign mem_req_wstrb = r_wen ? (r_wmask << r_addr[2:0]) : 8'h00;

`ifdef LSU_MISALIGN_CHECK_EN
    assign err = r_err & (r_state == S_DONE);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_stage
//
// Self-checking bench for lsu_mem_stage: a table of directed transactions,
// hand-written sequences for non-memory finish, reset mid-transaction and
// misaligned access, then randomized transactions checked against a
// byte-level reference model. Honours LSU_MISALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        data_ram_en;
    logic        data_ram_wen;
    logic [6:0]  l_choose;
    logic [7:0]  wmask;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        mem_finish;
    logic [63:0] rdata;
    logic        busy;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        mem_resp_ready;
    logic        err;

    int testsRun    = 0;
    int testsFailed = 0;

    lsu_mem_stage #(.ADDR_W(32), .XLEN(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .data_ram_en   (data_ram_en),
        .data_ram_wen  (data_ram_wen),
        .l_choose      (l_choose),
        .wmask         (wmask),
        .addr          (addr),
        .wdata         (wdata),
        .mem_finish    (mem_finish),
        .rdata         (rdata),
        .busy          (busy),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_ready(mem_resp_ready),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        wen;
        logic [6:0]  lchoose;
        logic [7:0]  wmask;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] respWord;
        int          readyDelay;
        int          respDelay;
        logic [63:0] expRdata;
        logic [31:0] expAddr;
        logic [7:0]  expWstrb;
        logic [63:0] expWdata;
        int          expCycles;
    } vec_t;

    vec_t vecs[8];

    // Comparison primitive; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
        end
    endtask

    // Reference model, stated as byte arithmetic on the access rules.
    function automatic int loadType(input logic [6:0] lc);
        for (int i = 0; i < 7; i++) if (lc[i]) return i;
        return 0;
    endfunction

    function automatic int loadSize(input logic [6:0] lc);
        case (loadType(lc))
            0:       return 8;
            1, 2:    return 4;
            3, 4:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int storeSize(input logic [7:0] m);
        if (m == 8'hFF) return 8;
        if (m == 8'h0F) return 4;
        if (m == 8'h03) return 2;
        return 1;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] v, input int bytes, input bit sgn);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
        r = v & mask;
        if (sgn && r[8*bytes-1]) r = r | ~mask;
        return r;
    endfunction

    function automatic logic [63:0] modelLoad(input logic [6:0] lc, input int off,
                                              input logic [63:0] word);
        logic [63:0] s;
        s = word >> (8 * off);
        case (loadType(lc))
            0:       return s;
            1:       return extend(s, 4, 1);
            2:       return extend(s, 4, 0);
            3:       return extend(s, 2, 1);
            4:       return extend(s, 2, 0);
            5:       return extend(s, 1, 1);
            default: return extend(s, 1, 0);
        endcase
    endfunction

    function automatic logic [7:0] modelStrb(input logic [7:0] m, input int off);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) if (m[i] && (i + off) < 8) r[i+off] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] modelWdata(input logic [63:0] d, input int off);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 8; i++)
            if ((i + off) < 8) r[8*(i+off) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Presents one instruction for a single cycle, then plays the bus with
    // the requested ready/response delays until mem_finish or a time limit.
    task automatic applyStimulus(
        input  logic        en, input logic wen, input logic [6:0] lc,
        input  logic [7:0]  m,  input logic [31:0] a, input logic [63:0] d,
        input  logic [63:0] respWord, input int readyDelay, input int respDelay,
        output int          finCycle, output logic [63:0] gotRdata, output logic gotErr,
        output int          reqCycles, output logic [31:0] gotAddr,
        output logic [7:0]  gotStrb, output logic [63:0] gotWdata,
        output logic        gotWen, output logic stable);
        int waitCycles;
        finCycle = -1; reqCycles = 0; waitCycles = 0; stable = 1'b1;
        gotRdata = '0; gotErr = 1'b0; gotAddr = '0; gotStrb = '0; gotWdata = '0; gotWen = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; data_ram_en = en; data_ram_wen = wen;
        l_choose = lc; wmask = m; addr = a; wdata = d;
        #1;
        if (mem_finish) begin finCycle = 0; gotRdata = rdata; gotErr = err; end
        for (int c = 1; c <= 60 && finCycle < 0; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; data_ram_en = 1'b0; data_ram_wen = 1'b0;
            l_choose = '0; wmask = '0; addr = '0; wdata = '0;
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
            #1;
            if (mem_req_valid) begin
                if (reqCycles == 0) begin
                    gotAddr = mem_req_addr; gotStrb = mem_req_wstrb;
                    gotWdata = mem_req_wdata; gotWen = mem_req_wen;
                end else if (gotAddr !== mem_req_addr || gotStrb !== mem_req_wstrb ||
                             gotWdata !== mem_req_wdata || gotWen !== mem_req_wen) begin
                    stable = 1'b0;
                end
                if (reqCycles >= readyDelay) mem_req_ready = 1'b1;
                reqCycles++;
            end
            if (mem_resp_ready) begin
                if (waitCycles >= respDelay) begin
                    mem_resp_valid = 1'b1; mem_resp_rdata = respWord;
                end
                waitCycles++;
            end
            if (mem_finish) begin finCycle = c; gotRdata = rdata; gotErr = err; end
        end
        if (finCycle < 0) $display("[TB] FAIL timeout: mem_finish never seen (limit 60 cycles)");
    endtask

    task automatic runAndCheck(
        input string tag, input logic en, input logic wen, input logic [6:0] lc,
        input logic [7:0] m, input logic [31:0] a, input logic [63:0] d,
        input logic [63:0] respWord, input int readyDelay, input int respDelay,
        input int expCycles, input logic [63:0] expRdata, input logic expErr,
        input logic expReq, input logic [31:0] expAddr, input logic [7:0] expStrb,
        input logic [63:0] expWdata);
        int finCycle, reqCycles;
        logic [63:0] gotRdata, gotWdata;
        logic gotErr, gotWen, stable;
        logic [31:0] gotAddr;
        logic [7:0] gotStrb;
        applyStimulus(en, wen, lc, m, a, d, respWord, readyDelay, respDelay,
                      finCycle, gotRdata, gotErr, reqCycles, gotAddr, gotStrb,
                      gotWdata, gotWen, stable);
        checkOutput({tag, " finish cycle"}, 64'(finCycle), 64'(expCycles));
        checkOutput({tag, " rdata"}, gotRdata, expRdata);
        checkOutput({tag, " err"}, 64'(gotErr), 64'(expErr));
        if (expReq) begin
            checkOutput({tag, " req cycles"}, 64'(reqCycles), 64'(readyDelay + 1));
            checkOutput({tag, " req addr"}, 64'(gotAddr), 64'(expAddr));
            checkOutput({tag, " wstrb"}, 64'(gotStrb), 64'(expStrb));
            checkOutput({tag, " req wdata"}, gotWdata, expWdata);
            checkOutput({tag, " req wen"}, 64'(gotWen), 64'(wen));
            checkOutput({tag, " req stable"}, 64'(stable), 64'd1);
        end else begin
            checkOutput({tag, " no request"}, 64'(reqCycles), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; data_ram_en = 1'b0; data_ram_wen = 1'b0;
        l_choose = '0; wmask = '0; addr = '0; wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

        vecs[0] = '{en:1, wen:0, lchoose:7'b0000010, wmask:8'h00, addr:32'h8000_0004,
                    wdata:64'd0, respWord:64'h8000_0000_1234_5678, readyDelay:0, respDelay:0,
                    expRdata:64'hFFFF_FFFF_8000_0000, expAddr:32'h8000_0000,
                    expWstrb:8'h00, expWdata:64'd0, expCycles:3};
        vecs[1] = '{en:1, wen:0, lchoose:7'b1000000, wmask:8'h00, addr:32'h8000_0003,
                    wdata:64'd0, respWord:64'h0000_0000_AB00_0000, readyDelay:0, respDelay:0,
                    expRdata:64'h0000_0000_0000_00AB, expAddr:32'h8000_0000,
                    expWstrb:8'h00, expWdata:64'd0, expCycles:3};
        vecs[2] = '{en:1, wen:0, lchoose:7'b0100000, wmask:8'h00, addr:32'h8000_0003,
                    wdata:64'd0, respWord:64'h0000_0000_AB00_0000, readyDelay:0, respDelay:0,
                    expRdata:64'hFFFF_FFFF_FFFF_FFAB, expAddr:32'h8000_0000,
                    expWstrb:8'h00, expWdata:64'd0, expCycles:3};
        vecs[3] = '{en:0, wen:1, lchoose:7'b0000000, wmask:8'h03, addr:32'h8000_0006,
                    wdata:64'h0000_0000_0000_BEEF, respWord:64'h1234, readyDelay:4, respDelay:0,
                    expRdata:64'd0, expAddr:32'h8000_0000,
                    expWstrb:8'hC0, expWdata:64'hBEEF_0000_0000_0000, expCycles:7};
        vecs[4] = '{en:1, wen:0, lchoose:7'b0000000, wmask:8'h00, addr:32'h8000_0010,
                    wdata:64'd0, respWord:64'h0123_4567_89AB_CDEF, readyDelay:0, respDelay:2,
                    expRdata:64'h0123_4567_89AB_CDEF, expAddr:32'h8000_0010,
                    expWstrb:8'h00, expWdata:64'd0, expCycles:5};
        vecs[5] = '{en:1, wen:0, lchoose:7'b0011000, wmask:8'h00, addr:32'h8000_0002,
                    wdata:64'd0, respWord:64'h0000_0000_8001_0000, readyDelay:1, respDelay:0,
                    expRdata:64'hFFFF_FFFF_FFFF_8001, expAddr:32'h8000_0000,
                    expWstrb:8'h00, expWdata:64'd0, expCycles:4};
        vecs[6] = '{en:1, wen:1, lchoose:7'b0000001, wmask:8'hFF, addr:32'h8000_0008,
                    wdata:64'hDEAD_BEEF_CAFE_F00D, respWord:64'h1111, readyDelay:1, respDelay:1,
                    expRdata:64'd0, expAddr:32'h8000_0008,
                    expWstrb:8'hFF, expWdata:64'hDEAD_BEEF_CAFE_F00D, expCycles:5};
        vecs[7] = '{en:1, wen:0, lchoose:7'b0000100, wmask:8'h00, addr:32'h8000_0000,
                    wdata:64'd0, respWord:64'hAAAA_BBBB_F000_0001, readyDelay:0, respDelay:0,
                    expRdata:64'h0000_0000_F000_0001, expAddr:32'h8000_0000,
                    expWstrb:8'h00, expWdata:64'd0, expCycles:3};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("reset mem_resp_ready", 64'(mem_resp_ready), 64'd0);
        checkOutput("reset mem_finish", 64'(mem_finish), 64'd0);
        checkOutput("reset rdata", rdata, 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].en, vecs[i].wen, vecs[i].lchoose,
                        vecs[i].wmask, vecs[i].addr, vecs[i].wdata, vecs[i].respWord,
                        vecs[i].readyDelay, vecs[i].respDelay, vecs[i].expCycles,
                        vecs[i].expRdata, 1'b0, 1'b1, vecs[i].expAddr, vecs[i].expWstrb,
                        vecs[i].expWdata);
        end

        // Non-memory instruction finishes in the same cycle.
        @(posedge clk); #1;
        req_valid = 1'b1; data_ram_en = 1'b0; data_ram_wen = 1'b0;
        #1;
        checkOutput("nonmem mem_finish", 64'(mem_finish), 64'd1);
        checkOutput("nonmem mem_req_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("nonmem busy", 64'(busy), 64'd0);
        req_valid = 1'b0;
        #1;
        checkOutput("idle mem_finish", 64'(mem_finish), 64'd0);

        // Reset in WAIT, then a late response in IDLE is ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; data_ram_en = 1'b1; l_choose = 7'b0000010; addr = 32'h8000_000C;
        wdata = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk); #1;
        req_valid = 1'b0; data_ram_en = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        #1;
        checkOutput("rstseq in wait", 64'(mem_resp_ready), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checkOutput("rstseq busy", 64'(busy), 64'd0);
        checkOutput("rstseq mem_resp_ready", 64'(mem_resp_ready), 64'd0);
        checkOutput("rstseq rdata", rdata, 64'd0);
        checkOutput("rstseq mem_req_addr", 64'(mem_req_addr), 64'd0);
        checkOutput("rstseq mem_req_wdata", mem_req_wdata, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            checkOutput($sformatf("rstseq late resp finish %0d", i), 64'(mem_finish), 64'd0);
            checkOutput($sformatf("rstseq late resp valid %0d", i),
                        64'({busy, mem_req_valid, err}), 64'd0);
        end
        mem_resp_valid = 1'b0; mem_resp_rdata = '0;

`ifdef LSU_MISALIGN_CHECK_EN
        // Misaligned ld: no bus traffic, err for exactly one cycle.
        runAndCheck("misalign ld", 1'b1, 1'b0, 7'b0000001, 8'h00, 32'h8000_0004, 64'd0,
                    64'h1234, 0, 0, 1, 64'd0, 1'b1, 1'b0, 32'd0, 8'h00, 64'd0);
        @(posedge clk); #2;
        checkOutput("misalign err drop", 64'(err), 64'd0);
`else
        // Misaligned sh straddling the word: upper strobe bit is dropped.
        runAndCheck("straddle sh", 1'b0, 1'b1, 7'b0000000, 8'h03, 32'h8000_0007,
                    64'h0000_0000_0000_BEEF, 64'h0, 0, 0, 3, 64'd0, 1'b0, 1'b1,
                    32'h8000_0000, 8'h80, 64'hEF00_0000_0000_0000);
`endif

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic        rEn, rWen, mis;
            logic [6:0]  rLc;
            logic [7:0]  rM;
            logic [31:0] rA;
            logic [63:0] rD, rW;
            int          rRd, rRsp, off, sz, sel;
            rWen = ($urandom_range(0, 2) == 0);
            rEn  = !rWen || ($urandom_range(0, 3) == 0);
            sel  = $urandom_range(0, 9);
            if (sel == 0)      rLc = 7'b0;
            else if (sel <= 7) rLc = 7'(1 << (sel - 1));
            else               rLc = 7'($urandom_range(0, 127));
            case ($urandom_range(0, 3))
                0:       rM = 8'h01;
                1:       rM = 8'h03;
                2:       rM = 8'h0F;
                default: rM = 8'hFF;
            endcase
            rA   = 32'h8000_0000 | 32'($urandom_range(0, 255));
            rD   = {$urandom, $urandom};
            rW   = {$urandom, $urandom};
            rRd  = $urandom_range(0, 3);
            rRsp = $urandom_range(0, 3);
            off  = int'(rA % 8);
            sz   = rWen ? storeSize(rM) : loadSize(rLc);
`ifdef LSU_MISALIGN_CHECK_EN
            mis = ((rA % sz) != 0);
`else
            mis = 1'b0;
`endif
            runAndCheck($sformatf("rand%0d", n), rEn, rWen, rLc, rM, rA, rD, rW, rRd, rRsp,
                        mis ? 1 : 3 + rRd + rRsp,
                        (mis || rWen) ? 64'd0 : modelLoad(rLc, off, rW),
                        mis, !mis, {rA[31:3], 3'b000},
                        rWen ? modelStrb(rM, off) : 8'h00, modelWdata(rD, off));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Memory-access stage of the RV64 NPC core; sits directly downstream of instruction decode/control. Consumes the decoded load/store controls (load enable, store enable, one-hot load type, byte write mask) plus the ALU-computed address and store data. Runs a valid/ready transaction on the data bus and returns the aligned, sign/zero-extended load result. Generates mem_finish, which control uses to gate register-file and CSR write enables.

Parameters:
ADDR_W, 32, data-bus address width
XLEN, 64, datapath width (fixed 64; bus is one 8-byte word)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  instruction present in MEM stage
data_ram_en  in  1  load request
data_ram_wen  in  1  store request
l_choose  in  7  one-hot load type: [0]ld [1]lw [2]lwu [3]lh [4]lhu [5]lb [6]lbu
wmask  in  8  store byte mask, unshifted (sb=0x01, sh=0x03, sw=0x0F, sd=0xFF)
addr  in  ADDR_W  effective byte address
wdata  in  64  store data, unshifted
mem_finish  out  1  stage may retire this cycle
rdata  out  64  extended load result; valid while mem_finish=1
busy  out  1  transaction in flight (state != IDLE)
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_wen  out  1  1=write, 0=read
mem_req_addr  out  ADDR_W  addr with [2:0] forced to 0
mem_req_wdata  out  64  wdata << (8*addr[2:0])
mem_req_wstrb  out  8  (wmask << addr[2:0]) truncated to 8 bits; 0 for reads
mem_resp_valid  in  1  bus response / write acknowledge
mem_resp_rdata  in  64  read word
mem_resp_ready  out  1  high only in WAIT
err  out  1  misaligned access (LSU_MISALIGN_CHECK_EN only; otherwise tied 0)

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE. All registered outputs and latched fields = 0; mem_req_valid=0, mem_resp_ready=0, busy=0, err=0, rdata=0. Applies mid-transaction; the in-flight bus beat is abandoned, and a late mem_resp_valid is ignored because resp_ready=0 outside WAIT.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: when req_valid & (data_ram_en | data_ram_wen), latch addr, wdata, wmask, l_choose and op, then go to REQ. If req_valid with neither enable set, mem_finish=1 combinationally in the same cycle (non-memory instructions take zero added latency). When req_valid=0, mem_finish=0.
- Enable conflict: if data_ram_en and data_ram_wen are both 1, the store wins.
- Load type decode: l_choose=0 on a load is treated as ld. If more than one bit is set, the lowest index wins.
- REQ: mem_req_valid=1 with all request fields driven from the latched values and held stable until mem_req_ready. On the valid&ready edge go to WAIT. Stores also wait for a response, which is the write acknowledge.
- WAIT: mem_resp_ready=1. On mem_resp_valid, capture mem_resp_rdata and go to DONE. A response arriving while in REQ is not accepted.
- DONE (one cycle): mem_finish=1 and rdata valid, then go to IDLE. A req_valid seen in IDLE on the following cycle is a new instruction; upstream advances on mem_finish.
- Minimum latency: request seen in IDLE at cycle 0, mem_finish at cycle 3 (ready and response each arrive in the first cycle of their state).
- Load extraction: sh = mem_resp_rdata >> (8*addr[2:0]).
  - ld: sh.
  - lw: sign-extend sh[31:0]; lwu: zero-extend sh[31:0].
  - lh: sign-extend sh[15:0]; lhu: zero-extend sh[15:0].
  - lb: sign-extend sh[7:0]; lbu: zero-extend sh[7:0].
  - Stores: rdata=0.
- Without the check, strobe bits shifted past bit 7 are dropped. No split transactions.

Optional Feature:
Macro LSU_MISALIGN_CHECK_EN.
- Defined: in IDLE, alignment is checked. ld/sd need addr[2:0]=0; lw/lwu/sw need addr[1:0]=0; lh/lhu/sh need addr[0]=0.
  - On violation, no bus request is issued. FSM goes IDLE to DONE directly; in DONE, mem_finish=1, err=1 (one cycle), rdata=0.
  - err is 0 in all other cycles.
- Undefined: no check; err tied 0; misaligned accesses truncate as described above.

Test Plan:
- lw at addr 0x80000004, resp word 0x80000000_12345678, ready and response immediate -> mem_req_addr=0x80000000, wstrb=0x00, mem_finish at cycle 3, rdata=0xFFFFFFFF_80000000.
- lbu at 0x80000003, resp 0x00000000_AB000000 -> rdata=0x00000000_000000AB; lb same data -> rdata=0xFFFFFFFF_FFFFFFAB.
- sh at 0x80000006, wmask=0x03, wdata=0xBEEF, ready delayed 4 cycles -> mem_req_valid held 5 cycles with stable fields, wstrb=0xC0, wdata=0xBEEF0000_00000000; mem_finish after ack, rdata=0.
- req_valid=1 with en=wen=0 -> mem_finish=1 same cycle, mem_req_valid stays 0, busy=0.
- Reset asserted while in WAIT, then mem_resp_valid=1 during the next IDLE -> outputs all 0, no mem_finish, response ignored.
- LSU_MISALIGN_CHECK_EN defined, ld at 0x80000004 -> no mem_req_valid, mem_finish=1 and err=1 one cycle after request, rdata=0.
